// File: rtl/mem_port_arbiter_if.sv
// Bus interfaces for the two-channel memory port arbiter.
// The channel bundle carries the packed Bambu Mout_*/M_* ram signals
// (channel 0 in the low slice, channel 1 in the high slice); the memory
// bundle is the single external memory port.

interface mem_port_arbiter_chan_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic [1:0]          Min_oe_ram;
  logic [1:0]          Min_we_ram;
  logic [2*ADDR_W-1:0] Min_addr_ram;
  logic [2*DATA_W-1:0] Min_Wdata_ram;
  logic [2*SIZE_W-1:0] Min_data_ram_size;
  logic [1:0]          M_DataRdy;
  logic [2*DATA_W-1:0] M_Rdata_ram;

  // The accelerator side issues requests and receives completions.
  modport master (
    output Min_oe_ram, Min_we_ram, Min_addr_ram, Min_Wdata_ram, Min_data_ram_size,
    input  M_DataRdy, M_Rdata_ram
  );

  // The arbiter side accepts requests and returns completions.
  modport slave (
    input  Min_oe_ram, Min_we_ram, Min_addr_ram, Min_Wdata_ram, Min_data_ram_size,
    output M_DataRdy, M_Rdata_ram
  );
endinterface

interface mem_port_arbiter_mem_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4
);
  logic              mem_oe;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [SIZE_W-1:0] mem_size;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_drdy;

  // The arbiter drives the memory port.
  modport master (
    output mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
    input  mem_rdata, mem_drdy
  );

  // The memory answers accesses.
  modport slave (
    input  mem_oe, mem_we, mem_addr, mem_wdata, mem_size,
    output mem_rdata, mem_drdy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the two
// master channels of a Bambu-generated accelerator. A granted access is
// held on the memory port until mem_drdy (or a watchdog abort), then a
// one-cycle completion pulse is routed back to the owning channel.
// Sticky flags record protocol violations and watchdog aborts.

module mem_port_arbiter #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 8,
  parameter int SIZE_W  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  mem_port_arbiter_chan_if.slave        chan,
  mem_port_arbiter_mem_if.master        mem,
  output logic                          proto_err,
  output logic                          timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic                rrPtr_q;
  logic                grant_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                memOe_q;
  logic                memWe_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q;
  logic [SIZE_W-1:0]   memSize_q;
  logic [1:0]          dataRdy_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic                protoErr_q;
  logic                timeoutErr_q;

  logic [1:0]          validReq;
  logic                bothSet;
  logic                grantId_d;
  logic                selRead_d;
  logic [ADDR_W-1:0]   selAddr_d;
  logic [DATA_W-1:0]   selWdata_d;
  logic [SIZE_W-1:0]   selSize_d;
  logic [DATA_W-1:0]   rspData_d;
  logic                issueDone;

  // Decode requests, choose the channel to grant and select its fields.
  always_comb begin
    validReq   = chan.Min_oe_ram ^ chan.Min_we_ram;
    bothSet    = |(chan.Min_oe_ram & chan.Min_we_ram);
    grantId_d  = 1'b0;
    if (validReq == 2'b11) begin
      grantId_d = rrPtr_q;
    end else if (validReq[1]) begin
      grantId_d = 1'b1;
    end
    selRead_d  = grantId_d ? chan.Min_oe_ram[1] : chan.Min_oe_ram[0];
    selAddr_d  = grantId_d ? chan.Min_addr_ram[2*ADDR_W-1:ADDR_W]
                           : chan.Min_addr_ram[ADDR_W-1:0];
    selWdata_d = grantId_d ? chan.Min_Wdata_ram[2*DATA_W-1:DATA_W]
                           : chan.Min_Wdata_ram[DATA_W-1:0];
    selSize_d  = grantId_d ? chan.Min_data_ram_size[2*SIZE_W-1:SIZE_W]
                           : chan.Min_data_ram_size[SIZE_W-1:0];
    rspData_d  = (mem.mem_drdy && memOe_q) ? mem.mem_rdata : '0;
    issueDone  = mem.mem_drdy || (cnt_q == CNT_W'(TIMEOUT - 1));
  end

  // Arbitration FSM; every output is a register cleared asynchronously so
  // the memory enables drop the moment reset is asserted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rrPtr_q      <= 1'b0;
      grant_q      <= 1'b0;
      cnt_q        <= '0;
      memOe_q      <= 1'b0;
      memWe_q      <= 1'b0;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      memSize_q    <= '0;
      dataRdy_q    <= '0;
      rdata_q      <= '0;
      protoErr_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
    end else begin
      if (bothSet) begin
        protoErr_q <= 1'b1;
      end
      dataRdy_q <= '0;
      rdata_q   <= '0;
      case (state_q)
        IDLE: begin
          if (|validReq) begin
            grant_q    <= grantId_d;
            memOe_q    <= selRead_d;
            memWe_q    <= ~selRead_d;
            memAddr_q  <= selAddr_d;
            memWdata_q <= selWdata_d;
            memSize_q  <= selSize_d;
            cnt_q      <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (issueDone) begin
            if (!mem.mem_drdy) begin
              timeoutErr_q <= 1'b1;
            end
            dataRdy_q  <= grant_q ? 2'b10 : 2'b01;
            rdata_q    <= grant_q ? {rspData_d, {DATA_W{1'b0}}}
                                  : {{DATA_W{1'b0}}, rspData_d};
            memOe_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            memSize_q  <= '0;
            state_q    <= RESP;
          end
        end
        RESP: begin
          rrPtr_q <= ~grant_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_oe       = memOe_q;
  assign mem.mem_we       = memWe_q;
  assign mem.mem_addr     = memAddr_q;
  assign mem.mem_wdata    = memWdata_q;
  assign mem.mem_size     = memSize_q;
  assign chan.M_DataRdy   = dataRdy_q;
  assign chan.M_Rdata_ram = rdata_q;
  assign proto_err        = protoErr_q;
  assign timeout_err      = timeoutErr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized
// phase, all compared cycle by cycle against a transaction-level model.

module tb_mem_port_arbiter;
  localparam int AW  = 11;
  localparam int DW  = 8;
  localparam int SW  = 4;
  localparam int TMO = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic protoErr;
  logic timeoutErr;

  always #5 clock = ~clock;

  mem_port_arbiter_chan_if #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) chanIf ();
  mem_port_arbiter_mem_if  #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW)) memIf ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TMO)) dut (
    .clock       (clock),
    .reset       (reset),
    .chan        (chanIf),
    .mem         (memIf),
    .proto_err   (protoErr),
    .timeout_err (timeoutErr)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Requesters
  logic          reqOe[2];
  logic          reqWe[2];
  logic [AW-1:0] reqAddr[2];
  logic [DW-1:0] reqWdata[2];
  logic [SW-1:0] reqSize[2];
  bit            reqHold[2];
  bit            autoReq = 0;
  int            reqRate = 0;
  logic [1:0]    lastDrdy = 2'b00;

  // Memory behaviour: 0 random, 1 Bambu timing, 2 never answers
  int            memMode = 0;
  int            memCycles = 0;
  logic [DW-1:0] memFixed = 8'h5A;

  // Transaction-level reference model
  bit            mBusy, mRead, mRespValid, mProto, mTmo;
  int            mOwner, mElapsed, mRespCh, mPref;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata, mRespData;
  logic [SW-1:0] mSize;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mRead = 0; mRespValid = 0; mProto = 0; mTmo = 0;
    mOwner = 0; mElapsed = 0; mRespCh = 0; mPref = 0;
    mAddr = '0; mWdata = '0; mSize = '0; mRespData = '0;
  endtask

  task automatic clearRequesters();
    for (int c = 0; c < 2; c++) begin
      reqOe[c] = 0; reqWe[c] = 0; reqAddr[c] = '0;
      reqWdata[c] = '0; reqSize[c] = '0; reqHold[c] = 0;
    end
  endtask

  task automatic setReq(int c, bit isRead, logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    reqOe[c] = isRead; reqWe[c] = !isRead;
    reqAddr[c] = a; reqWdata[c] = d; reqSize[c] = s; reqHold[c] = 1;
  endtask

  task automatic packRequests();
    for (int c = 0; c < 2; c++) begin
      chanIf.Min_oe_ram[c] = reqOe[c];
      chanIf.Min_we_ram[c] = reqWe[c];
      chanIf.Min_addr_ram[c*AW +: AW] = reqAddr[c];
      chanIf.Min_Wdata_ram[c*DW +: DW] = reqWdata[c];
      chanIf.Min_data_ram_size[c*SW +: SW] = reqSize[c];
    end
  endtask

  // Drive requester and memory behaviour for the coming cycle.
  task automatic applyStimulus();
    for (int c = 0; c < 2; c++) begin
      if (reqHold[c] && lastDrdy[c]) begin
        reqHold[c] = 0; reqOe[c] = 0; reqWe[c] = 0;
      end else if (autoReq && !reqHold[c] && ($urandom_range(0, 99) < reqRate)) begin
        setReq(c, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), SW'($urandom));
      end
    end
    packRequests();
    if (memIf.mem_oe === 1'b1 || memIf.mem_we === 1'b1) memCycles++;
    else memCycles = 0;
    case (memMode)
      0: begin
        memIf.mem_rdata = DW'($urandom);
        memIf.mem_drdy  = (memCycles > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 5) == 0);
      end
      1: begin
        memIf.mem_rdata = memFixed;
        memIf.mem_drdy  = (memIf.mem_oe === 1'b1) ? (memCycles == 2) :
                          (memIf.mem_we === 1'b1) ? (memCycles == 1) : 1'b0;
      end
      default: begin
        memIf.mem_rdata = DW'($urandom);
        memIf.mem_drdy  = 1'b0;
      end
    endcase
  endtask

  task automatic compareAll();
    logic [2*DW-1:0] expR;
    expR = '0;
    if (mRespValid) expR = (2*DW)'(mRespData) << (DW * mRespCh);
    checkOutput("mem_oe",      memIf.mem_oe,    32'(mBusy && mRead));
    checkOutput("mem_we",      memIf.mem_we,    32'(mBusy && !mRead));
    checkOutput("mem_addr",    memIf.mem_addr,  mBusy ? 32'(mAddr) : 32'd0);
    checkOutput("mem_wdata",   memIf.mem_wdata, mBusy ? 32'(mWdata) : 32'd0);
    checkOutput("mem_size",    memIf.mem_size,  mBusy ? 32'(mSize) : 32'd0);
    checkOutput("M_DataRdy",   chanIf.M_DataRdy, mRespValid ? (32'd1 << mRespCh) : 32'd0);
    checkOutput("M_Rdata_ram", chanIf.M_Rdata_ram, 32'(expR));
    checkOutput("proto_err",   protoErr,   32'(mProto));
    checkOutput("timeout_err", timeoutErr, 32'(mTmo));
  endtask

  // Advance the model by one clock using the inputs seen this cycle.
  task automatic modelStep();
    int cand[$];
    if (!reset) begin
      modelReset();
      return;
    end
    for (int c = 0; c < 2; c++) if (reqOe[c] && reqWe[c]) mProto = 1;
    if (mRespValid) begin
      mRespValid = 0;
      mPref = 1 - mRespCh;
    end else if (mBusy) begin
      mElapsed++;
      if (memIf.mem_drdy) begin
        mRespValid = 1; mRespCh = mOwner; mBusy = 0;
        mRespData = mRead ? memIf.mem_rdata : '0;
      end else if (mElapsed == TMO) begin
        mRespValid = 1; mRespCh = mOwner; mBusy = 0;
        mRespData = '0; mTmo = 1;
      end
    end else begin
      for (int c = 0; c < 2; c++) if (reqOe[c] != reqWe[c]) cand.push_back(c);
      if (cand.size() > 0) begin
        mOwner = (cand.size() == 2) ? mPref : cand[0];
        mRead = reqOe[mOwner]; mAddr = reqAddr[mOwner];
        mWdata = reqWdata[mOwner]; mSize = reqSize[mOwner];
        mBusy = 1; mElapsed = 0;
      end
    end
  endtask

  task automatic tick();
    applyStimulus();
    @(negedge clock);
    compareAll();
    modelStep();
    lastDrdy = chanIf.M_DataRdy;
    @(posedge clock);
    #1;
  endtask

  task automatic waitIdle(int budget);
    for (int i = 0; i < budget; i++) begin
      if (!reqHold[0] && !reqHold[1] && !mBusy && !mRespValid) break;
      tick();
    end
    checkOutput("waitIdle", {30'd0, 1'(reqHold[1]), 1'(reqHold[0])}, 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    int pulses;
    int prevCh;
    clearRequesters();
    packRequests();
    memIf.mem_drdy  = 1'b0;
    memIf.mem_rdata = '0;
    modelReset();
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Simultaneous requests: ch0 read first, ch1 write second
    memMode = 1;
    setReq(0, 1, 11'h300, 8'h00, 4'h1);
    setReq(1, 0, 11'h380, 8'hC3, 4'h1);
    waitIdle(40);

    // Single read on ch0
    memFixed = 8'h5A;
    setReq(0, 1, 11'h280, 8'h00, 4'h1);
    waitIdle(20);

    // Fairness under continuous demand
    autoReq = 1; reqRate = 100; pulses = 0; prevCh = 0;
    for (int i = 0; i < 80 && pulses < 6; i++) begin
      tick();
      if (lastDrdy != 2'b00) begin
        if (pulses > 0) checkOutput("fairAlt", 32'(lastDrdy[1]), 32'(1 - prevCh));
        prevCh = int'(lastDrdy[1]);
        pulses++;
      end
    end
    checkOutput("fairCount", pulses, 6);
    autoReq = 0;
    waitIdle(20);

    // Watchdog abort
    memMode = 2;
    setReq(0, 1, 11'h123, 8'h00, 4'h2);
    waitIdle(20);
    checkOutput("timeoutFlag", timeoutErr, 1);

    // Randomized traffic
    memMode = 0; autoReq = 1; reqRate = 30;
    repeat (1500) tick();
    autoReq = 0;
    waitIdle(40);

    // Protocol violation on ch1
    reqOe[1] = 1; reqWe[1] = 1;
    repeat (4) tick();
    reqOe[1] = 0; reqWe[1] = 0;
    repeat (4) tick();
    checkOutput("protoSticky", protoErr, 1);

    // Asynchronous reset during a write
    memMode = 2;
    setReq(0, 0, 11'h055, 8'hA7, 4'h1);
    for (int i = 0; i < 10 && memIf.mem_we !== 1'b1; i++) tick();
    checkOutput("waitMemWe", memIf.mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstMemWe",   memIf.mem_we, 0);
    checkOutput("rstMemOe",   memIf.mem_oe, 0);
    checkOutput("rstDataRdy", chanIf.M_DataRdy, 0);
    checkOutput("rstProto",   protoErr, 0);
    checkOutput("rstTimeout", timeoutErr, 0);
    clearRequesters();
    packRequests();
    modelReset();
    lastDrdy = 2'b00;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;

    // First request after reset comes from ch1 only
    memMode = 1;
    memFixed = 8'h3C;
    setReq(1, 1, 11'h7FF, 8'h00, 4'h3);
    waitIdle(20);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
